// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Optional divide datapath is selected with MDU_DIV_EN.
package mdu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned RD_W  = 5;

   localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
   localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
   localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
   localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
   localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
   localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
   localparam logic [F3_W-1:0] F3_REM    = 3'b110;
   localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

   localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Operation context latched on accept
   typedef struct packed {
      logic [F3_W-1:0] funct3;
      logic            neg;
   } op_t;

endpackage

// File: rtl/mdu_if.sv
// Request/response handshake bundle between the pipeline and the MDU.
// Used identically with or without MDU_DIV_EN.
interface mdu_if;

   logic                          i_valid;
   logic                          o_ready;
   logic [mdu_pkg::F3_W-1:0]      i_funct3;
   logic [mdu_pkg::XLEN-1:0]      i_rs1;
   logic [mdu_pkg::XLEN-1:0]      i_rs2;
   logic [mdu_pkg::RD_W-1:0]      i_rd_waddr;
   logic                          i_flush;
   logic                          o_valid;
   logic                          i_ready;
   logic [mdu_pkg::XLEN-1:0]      o_result;
   logic [mdu_pkg::RD_W-1:0]      o_rd_waddr;

   modport slave (
      input  i_valid, i_funct3, i_rs1, i_rs2, i_rd_waddr, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_rd_waddr
   );

   modport master (
      output i_valid, i_funct3, i_rs1, i_rs2, i_rd_waddr, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_rd_waddr
   );

endinterface

// File: rtl/mdu_div_core.sv
// Restoring divide iteration: one subtract-shift step per cycle on magnitudes.
// Compiled only when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_div_core
   import mdu_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quot_c,
   output logic [XLEN-1:0] rem_c
);

   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quot_q;
   logic [XLEN-1:0] dsor_q;
   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;

   // Trial subtract of the shifted partial remainder; keep it if non-negative
   always_comb begin
      trial = {rem_q, quot_q[XLEN-1]};
      diff  = trial - {1'b0, dsor_q};
      if (diff[XLEN]) begin
         rem_c  = trial[XLEN-1:0];
         quot_c = {quot_q[XLEN-2:0], 1'b0};
      end else begin
         rem_c  = diff[XLEN-1:0];
         quot_c = {quot_q[XLEN-2:0], 1'b1};
      end
   end

   // Partial remainder / quotient / divisor registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rem_q  <= '0;
         quot_q <= '0;
         dsor_q <= '0;
      end else if (load) begin
         rem_q  <= '0;
         quot_q <= dividend;
         dsor_q <= divisor;
      end else if (step) begin
         rem_q  <= rem_c;
         quot_q <= quot_c;
      end
   end

endmodule
`endif

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// MDU_DIV_EN enables the divide datapath; without it divide ops return 0 in one cycle.
module mdu
   import mdu_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   mdu_if.slave bus
);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   op_t                 op_q;
   logic [XLEN-1:0]     mcand_q;
   logic [2*XLEN-1:0]   prod_q;
   logic [2*XLEN-1:0]   prod_nxt;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN:0]       add_sum;
   logic [XLEN-1:0]     mul_res;
   logic [XLEN-1:0]     final_res;
   logic                accept;
   logic                early;
   logic [XLEN-1:0]     early_res;
   logic                sgn1;
   logic                sgn2;
   logic                neg_in;
   logic [XLEN-1:0]     mag1;
   logic [XLEN-1:0]     mag2;
   logic                load;
   logic                step;
   logic                ready_d;
   logic                valid_d;
   logic [XLEN-1:0]     result_d;
   logic [RD_W-1:0]     rd_d;

   assign accept = (state == S_IDLE) & bus.i_valid & ~bus.i_flush;

   // Operand signedness, magnitudes and the sign of the final result
   always_comb begin
      sgn1 = 1'b0;
      sgn2 = 1'b0;
      case (bus.i_funct3)
         F3_MULH, F3_DIV, F3_REM: begin
            sgn1 = bus.i_rs1[XLEN-1];
            sgn2 = bus.i_rs2[XLEN-1];
         end
         F3_MULHSU: sgn1 = bus.i_rs1[XLEN-1];
         default: ;
      endcase
      mag1   = sgn1 ? -bus.i_rs1 : bus.i_rs1;
      mag2   = sgn2 ? -bus.i_rs2 : bus.i_rs2;
      // Remainder follows the dividend; everything else follows the sign product
      neg_in = (bus.i_funct3[2] & bus.i_funct3[1]) ? sgn1 : (sgn1 ^ sgn2);
   end

`ifdef MDU_DIV_EN
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] quot_nxt;
   logic [XLEN-1:0] rem_nxt;
   logic [XLEN-1:0] div_res;

   // Divide-by-zero and signed-overflow results are known at accept time
   always_comb begin
      div_zero  = bus.i_funct3[2] & (bus.i_rs2 == '0);
      div_ovf   = bus.i_funct3[2] & ~bus.i_funct3[0] &
                  (bus.i_rs1 == INT_MIN) & (bus.i_rs2 == '1);
      early     = div_zero | div_ovf;
      early_res = '0;
      if (div_zero)
         early_res = bus.i_funct3[1] ? bus.i_rs1 : '1;
      else if (div_ovf)
         early_res = bus.i_funct3[1] ? '0 : INT_MIN;
   end

   mdu_div_core u_div (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .load     (load),
      .step     (step),
      .dividend (mag1),
      .divisor  (mag2),
      .quot_c   (quot_nxt),
      .rem_c    (rem_nxt)
   );

   // Sign-corrected quotient or remainder from the last step
   always_comb begin
      if (op_q.funct3[1])
         div_res = op_q.neg ? -rem_nxt : rem_nxt;
      else
         div_res = op_q.neg ? -quot_nxt : quot_nxt;
   end

   assign final_res = op_q.funct3[2] ? div_res : mul_res;
`else
   // Without a divider every divide op completes immediately with zero
   assign early     = bus.i_funct3[2];
   assign early_res = '0;
   assign final_res = mul_res;
`endif

   // Shift-add multiply step and sign-corrected half selection
   always_comb begin
      add_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_nxt = {add_sum, prod_q[XLEN-1:1]};
      prod_fix = op_q.neg ? -prod_nxt : prod_nxt;
      mul_res  = (op_q.funct3 == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // FSM next state; flush always returns to IDLE
   always_comb begin
      state_nxt = state;
      if (bus.i_flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (bus.i_valid) state_nxt = early ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_nxt = S_DONE;
            S_DONE:  if (bus.i_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM outputs: datapath strobes and next values of the registered outputs
   always_comb begin
      ready_d  = (state_nxt == S_IDLE);
      valid_d  = (state_nxt == S_DONE);
      result_d = bus.o_result;
      rd_d     = bus.o_rd_waddr;
      cnt_d    = cnt_q;
      load     = 1'b0;
      step     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               load  = 1'b1;
               cnt_d = CNT_W'(ITER - 1);
               rd_d  = bus.i_rd_waddr;
               if (early) result_d = early_res;
            end
         end
         S_BUSY: begin
            if (!bus.i_flush) begin
               step  = 1'b1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) result_d = final_res;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q          <= '0;
         op_q           <= '0;
         mcand_q        <= '0;
         prod_q         <= '0;
         bus.o_ready    <= 1'b1;
         bus.o_valid    <= 1'b0;
         bus.o_result   <= '0;
         bus.o_rd_waddr <= '0;
      end else begin
         cnt_q          <= cnt_d;
         bus.o_ready    <= ready_d;
         bus.o_valid    <= valid_d;
         bus.o_result   <= result_d;
         bus.o_rd_waddr <= rd_d;
         if (load) begin
            op_q.funct3 <= bus.i_funct3;
            op_q.neg    <= neg_in;
            mcand_q     <= mag1;
            prod_q      <= {{XLEN{1'b0}}, mag2};
         end else if (step) begin
            prod_q      <= prod_nxt;
         end
      end
   end

endmodule
